cp0_regfile: RTL and testbench
==============================

# cp0_regfile

Coprocessor-0 register file for the 5-stage MIPS pipeline. It consumes the exception/eret/mtc0 bus driven by the write-back stage and returns the mfc0 read data, the pending-interrupt flag, and the exception return address. It implements BadVAddr, Count, Compare, Status, Cause and EPC (sel 0 only) and the Count/Compare timer interrupt.

## Interface
- No parameters; register map fixed: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wb_to_cp0_bus  in  110  fields:
  - [109] ex: exception commit, already qualified by WB valid
  - [108:104] excode
  - [103:72] badvaddr
  - [71] bd
  - [70:39] pc
  - [38] mtc0_we
  - [37:33] cp0_addr
  - [32:1] wdata (rt value)
  - [0] eret
- ext_int_in  in  6  hardware interrupt lines, level, active-high
- cp0_rdata  out  32  combinational read of register cp0_addr; unmapped addresses read 0
- has_int  out  1  interrupt pending and enabled
- epc_out  out  32  current EPC, used by the fetch stage on eret

## Operation
- Status: BEV[22] is read-only, 1. IM[15:8], EXL[1] and IE[0] are writable by mtc0. All other bits read 0.
- Cause fields:
  - BD[31] and TI[30] are read-only.
  - IP[7:2] is hardware. Every cycle IP7 <= ext_int_in[5] | TI and IP[6:2] <= ext_int_in[4:0].
  - IP[1:0] is writable by mtc0.
  - ExcCode[6:2] is read-only to mtc0.
  - All other bits read 0.
- Exception commit (ex=1):
  - EXL <= 1 and ExcCode <= excode.
  - If EXL was 0 before the edge: EPC <= bd ? pc-4 : pc, and BD <= bd. If EXL was already 1, EPC and BD are unchanged.
  - If excode is 5'h04 (AdEL) or 5'h05 (AdES): BadVAddr <= badvaddr. Other excodes leave BadVAddr unchanged.
- eret=1 with ex=0: EXL <= 0.
- mtc0_we=1 writes cp0_addr with wdata, honouring the writable masks. Writes to read-only registers or unmapped addresses are ignored.
- Priority on the same edge: ex > eret > mtc0 for EXL and the Cause fields. An mtc0 to EPC or BadVAddr is ignored when ex=1.
- Timer:
  - A 1-bit tick toggles every cycle. Count increments (wrapping at 32 bits) on edges where tick==1 pre-edge.
  - An mtc0 to Count loads wdata, overrides the increment that cycle, and does not reset tick.
  - TI <= 1 when Count==Compare (registered values, pre-edge) and tick==1.
  - An mtc0 to Compare loads Compare and clears TI; this clear beats a same-cycle set. TI stays at 1 otherwise.
- has_int = |(Cause[15:8] & Status[15:8]) & IE & ~EXL. It is combinational from the registers.

## Timing
- Reset values:
  - Status = 32'h0040_0000; Cause, EPC, BadVAddr, Count and Compare = 0; tick = 0.
  - has_int = 0 and epc_out = 0.
- All register updates land on the rising clk edge; reads are zero-latency.
- A value written by mtc0 is visible on cp0_rdata in the next cycle. An mfc0 in WB one cycle after an mtc0 sees the new value.
- epc_out updates the cycle after ex. eret issued one cycle after ex returns the new EPC.
- ext_int_in reaches has_int after 1 cycle, through the IP register.
- Count after reset: 0, 0, 1, 1, 2, … (first increment at the 2nd edge).
- Reset asserted mid-operation restores all reset values on that edge, regardless of ex, eret or mtc0.

## Test plan
- mtc0 Status with wdata=32'hFFFF_FFFF, then read addr 12 -> 32'h0040_FF03. mtc0 Cause with 32'hFFFF_FFFF, then read addr 13 -> 32'h0000_0300.
- ex, excode=5'h04, pc=32'hBFC0_0100, bd=1, badvaddr=32'h1234_5671 -> EPC=32'hBFC0_00FC, Cause=32'h8000_0010, BadVAddr=32'h1234_5671, EXL=1. A second ex with pc=32'h8000_0000 -> EPC unchanged, ExcCode updated. eret -> EXL=0.
- Compare=5, Status=32'h0040_8001, Count=0 -> TI=1 and has_int=1 around cycle 12. mtc0 Compare=100 -> TI=0 and has_int=0 the next cycle.
- ext_int_in=6'b000001, IM2=1, IE=1, EXL=0 -> has_int=1 one cycle later. Setting EXL=1 via ex -> has_int=0.
- Same-cycle ex and mtc0 to Status with EXL=0 -> EXL=1. Same-cycle mtc0 to Compare and a Count==Compare match -> TI=0.
- Reset asserted mid-timer with Count=32'hFFFF_FFFF -> all registers return to their reset values. Without reset, Count wraps to 0.

Source files
------------

// File: rtl/cp0_regfile_if.sv
// Write-back to CP0 connection: the packed exception/eret/mtc0 bus plus the
// interrupt lines going in, and the mfc0 data, interrupt flag and EPC coming back.
interface cp0_regfile_if;
  // No valid/ready pair: WB qualifies ex, eret and mtc0_we itself, and every
  // asserted strobe is consumed unconditionally on the next rising clk edge.
  logic [109:0] wb_to_cp0_bus;
  logic [5:0]   ext_int_in;
  logic [31:0]  cp0_rdata;
  logic         has_int;
  logic [31:0]  epc_out;

  modport master (
    output wb_to_cp0_bus,
    output ext_int_in,
    input  cp0_rdata,
    input  has_int,
    input  epc_out
  );

  modport slave (
    input  wb_to_cp0_bus,
    input  ext_int_in,
    output cp0_rdata,
    output has_int,
    output epc_out
  );
endinterface

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC,
// exception/eret sequencing and the Count/Compare timer interrupt.
module cp0_regfile (
  input  logic          clk,
  input  logic          reset,
  cp0_regfile_if.slave  bus
);
  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  logic        ex;
  logic [4:0]  excode;
  logic [31:0] ex_badvaddr;
  logic        ex_bd;
  logic [31:0] ex_pc;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] wdata;
  logic        eret;

  assign ex          = bus.wb_to_cp0_bus[109];
  assign excode      = bus.wb_to_cp0_bus[108:104];
  assign ex_badvaddr = bus.wb_to_cp0_bus[103:72];
  assign ex_bd       = bus.wb_to_cp0_bus[71];
  assign ex_pc       = bus.wb_to_cp0_bus[70:39];
  assign mtc0_we     = bus.wb_to_cp0_bus[38];
  assign cp0_addr    = bus.wb_to_cp0_bus[37:33];
  assign wdata       = bus.wb_to_cp0_bus[32:1];
  assign eret        = bus.wb_to_cp0_bus[0];

  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] epc;
  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exccode;
  logic        tick;

  logic wr_badvaddr, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic is_addr_exc;

  assign wr_badvaddr = mtc0_we && (cp0_addr == ADDR_BADVADDR);
  assign wr_count    = mtc0_we && (cp0_addr == ADDR_COUNT);
  assign wr_compare  = mtc0_we && (cp0_addr == ADDR_COMPARE);
  assign wr_status   = mtc0_we && (cp0_addr == ADDR_STATUS);
  assign wr_cause    = mtc0_we && (cp0_addr == ADDR_CAUSE);
  assign wr_epc      = mtc0_we && (cp0_addr == ADDR_EPC);
  assign is_addr_exc = (excode == 5'h04) || (excode == 5'h05);

  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr      <= '0;
      count         <= '0;
      compare       <= '0;
      epc           <= '0;
      status_im     <= '0;
      status_exl    <= 1'b0;
      status_ie     <= 1'b0;
      cause_bd      <= 1'b0;
      cause_ti      <= 1'b0;
      cause_ip_hw   <= '0;
      cause_ip_sw   <= '0;
      cause_exccode <= '0;
      tick          <= 1'b0;
    end else begin
      tick <= ~tick;

      // Count advances every other cycle; a software load wins over the increment.
      if (wr_count)  count <= wdata;
      else if (tick) count <= count + 32'd1;

      if (wr_compare) compare <= wdata;

      if (wr_compare)                       cause_ti <= 1'b0;
      else if ((count == compare) && tick)  cause_ti <= 1'b1;

      cause_ip_hw <= {bus.ext_int_in[5] | cause_ti, bus.ext_int_in[4:0]};
      if (wr_cause) cause_ip_sw <= wdata[9:8];

      if (wr_status) begin
        status_im <= wdata[15:8];
        status_ie <= wdata[0];
      end

      if (ex)             status_exl <= 1'b1;
      else if (eret)      status_exl <= 1'b0;
      else if (wr_status) status_exl <= wdata[1];

      // A nested exception (EXL already set) keeps the original EPC and BD.
      if (ex) begin
        cause_exccode <= excode;
        if (!status_exl) begin
          epc      <= ex_bd ? (ex_pc - 32'd4) : ex_pc;
          cause_bd <= ex_bd;
        end
        if (is_addr_exc) badvaddr <= ex_badvaddr;
      end else begin
        if (wr_epc)      epc      <= wdata;
        if (wr_badvaddr) badvaddr <= wdata;
      end
    end
  end

  logic [31:0] status_val;
  logic [31:0] cause_val;
  logic [7:0]  cause_ip;

  assign cause_ip   = {cause_ip_hw, cause_ip_sw};
  assign status_val = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
  assign cause_val  = {cause_bd, cause_ti, 14'b0, cause_ip, 1'b0, cause_exccode, 2'b0};

  always_comb begin
    bus.cp0_rdata = '0;
    case (cp0_addr)
      ADDR_BADVADDR: bus.cp0_rdata = badvaddr;
      ADDR_COUNT:    bus.cp0_rdata = count;
      ADDR_COMPARE:  bus.cp0_rdata = compare;
      ADDR_STATUS:   bus.cp0_rdata = status_val;
      ADDR_CAUSE:    bus.cp0_rdata = cause_val;
      ADDR_EPC:      bus.cp0_rdata = epc;
      default:       bus.cp0_rdata = '0;
    endcase
  end

  assign bus.has_int = (|(cause_ip & status_im)) & status_ie & ~status_exl;
  assign bus.epc_out = epc;
endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios followed by random
// traffic, all compared against a field-level behavioural model.
module tb_cp0_regfile;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  cp0_regfile_if bus_if ();
  cp0_regfile dut (.clk(clk), .reset(reset), .bus(bus_if));

  int checks = 0;
  int errors = 0;
  logic [5:0] cur_ext = 6'h0;

  // Behavioural model, kept as named architectural fields.
  logic [31:0] m_count, m_compare, m_epc, m_badv;
  logic        m_tick, m_ti, m_exl, m_ie, m_bd;
  logic [7:0]  m_im;
  logic [5:0]  m_iphw;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;

  function automatic logic [109:0] pack(input logic ex_, input logic [4:0] code,
      input logic [31:0] bva, input logic bd_, input logic [31:0] pc_, input logic we,
      input logic [4:0] addr, input logic [31:0] wd, input logic er);
    return {ex_, code, bva, bd_, pc_, we, addr, wd, er};
  endfunction

  function automatic logic [7:0] m_ip();
    return {m_iphw, m_ipsw};
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a);
    case (a)
      5'd8:  return m_badv;
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13: return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_code) << 2);
      5'd14: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_has_int();
    return ((m_ip() & m_im) != 8'h0) && m_ie && !m_exl;
  endfunction

  task automatic model_edge(input logic [109:0] b, input logic [5:0] ext, input logic rst);
    logic ex_, bd_, we, er;
    logic [4:0] code, addr;
    logic [31:0] bva, pc_, wd, o_count, o_compare;
    logic o_tick, o_ti, o_exl;
    {ex_, code, bva, bd_, pc_, we, addr, wd, er} = b;
    if (rst) begin
      m_count = 0; m_compare = 0; m_epc = 0; m_badv = 0;
      m_tick = 0; m_ti = 0; m_exl = 0; m_ie = 0; m_bd = 0;
      m_im = 0; m_iphw = 0; m_ipsw = 0; m_code = 0;
      return;
    end
    o_count = m_count; o_compare = m_compare; o_tick = m_tick; o_ti = m_ti; o_exl = m_exl;
    m_tick = !o_tick;
    if (we && addr == 5'd9) m_count = wd;
    else if (o_tick) m_count = o_count + 1;
    if (we && addr == 5'd11) begin
      m_compare = wd;
      m_ti = 0;
    end else if (o_count == o_compare && o_tick) m_ti = 1;
    m_iphw = {ext[5] | o_ti, ext[4:0]};
    if (we && addr == 5'd13) m_ipsw = wd[9:8];
    if (we && addr == 5'd12) begin
      m_im = wd[15:8];
      m_ie = wd[0];
    end
    if (ex_) m_exl = 1;
    else if (er) m_exl = 0;
    else if (we && addr == 5'd12) m_exl = wd[1];
    if (ex_) begin
      m_code = code;
      if (!o_exl) begin
        m_epc = bd_ ? pc_ - 4 : pc_;
        m_bd = bd_;
      end
      if (code == 5'h04 || code == 5'h05) m_badv = bva;
    end else if (we && addr == 5'd14) m_epc = wd;
    else if (we && addr == 5'd8) m_badv = wd;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [109:0] b, input logic rst);
    bus_if.wb_to_cp0_bus = b;
    bus_if.ext_int_in = cur_ext;
    reset = rst;
    @(posedge clk);
    model_edge(b, cur_ext, rst);
    #1;
    bus_if.wb_to_cp0_bus = '0;
    reset = 1'b0;
  endtask

  task automatic idle();
    step('0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(pack(0, 0, 0, 0, 0, 1, a, d, 0), 1'b0);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    bus_if.wb_to_cp0_bus = pack(0, 0, 0, 0, 0, 0, a, 0, 0);
    #1;
    v = bus_if.cp0_rdata;
  endtask

  task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic check_all(input string tag);
    logic [4:0] addrs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd10};
    for (int i = 0; i < 8; i++) check_reg($sformatf("%s_r%0d", tag, addrs[i]), addrs[i], mread(addrs[i]));
    check({tag, "_has_int"}, {31'b0, bus_if.has_int}, {31'b0, m_has_int()});
    check({tag, "_epc_out"}, bus_if.epc_out, m_epc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic found;
    logic [4:0] raddrs [9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd10, 5'd31};
    bus_if.wb_to_cp0_bus = '0;
    bus_if.ext_int_in = '0;

    step('0, 1'b1);
    step('0, 1'b1);
    check_all("reset");
    check_reg("reset_status", 5'd12, 32'h0040_0000);
    check("reset_epc_out", bus_if.epc_out, 32'h0);
    check("reset_has_int", {31'b0, bus_if.has_int}, 32'h0);

    // Writable masks of Status and Cause.
    wr(5'd11, 32'hFFFF_0000);
    idle();
    wr(5'd12, 32'hFFFF_FFFF);
    check_reg("status_mask", 5'd12, 32'h0040_FF03);
    wr(5'd13, 32'hFFFF_FFFF);
    check_reg("cause_mask", 5'd13, 32'h0000_0300);
    check_all("masks");
    wr(5'd12, 32'h0);
    wr(5'd13, 32'h0);

    // Exception in a delay slot, nested exception, eret.
    step(pack(1, 5'h04, 32'h1234_5671, 1, 32'hBFC0_0100, 0, 0, 0, 0), 1'b0);
    check("ex1_epc_out", bus_if.epc_out, 32'hBFC0_00FC);
    check_reg("ex1_cause", 5'd13, 32'h8000_0010);
    check_reg("ex1_badv", 5'd8, 32'h1234_5671);
    check_reg("ex1_status", 5'd12, 32'h0040_0002);
    step(pack(1, 5'h08, 32'h5555_5555, 0, 32'h8000_0000, 1, 5'd14, 32'hDEAD_BEEF, 0), 1'b0);
    check_reg("ex2_epc", 5'd14, 32'hBFC0_00FC);
    check_reg("ex2_cause", 5'd13, 32'h8000_0020);
    check_reg("ex2_badv", 5'd8, 32'h1234_5671);
    step(pack(0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0);
    check_reg("eret_status", 5'd12, 32'h0040_0000);
    step(pack(1, 5'h0C, 0, 0, 32'h0000_1000, 0, 0, 0, 0), 1'b0);
    check("ex3_epc_out", bus_if.epc_out, 32'h0000_1000);
    step(pack(0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0);
    check_all("after_eret");

    // Timer interrupt.
    wr(5'd11, 32'd5);
    wr(5'd12, 32'h0040_8001);
    wr(5'd9, 32'd0);
    for (int i = 0; i < 30; i++) begin
      idle();
      check_all($sformatf("timer%0d", i));
    end
    rd(5'd13, v);
    check("timer_ti", {31'b0, v[30]}, 32'h1);
    check("timer_has_int", {31'b0, bus_if.has_int}, 32'h1);
    wr(5'd11, 32'd100);
    rd(5'd13, v);
    check("compare_clr_ti", {31'b0, v[30]}, 32'h0);
    idle();
    check("compare_clr_has_int", {31'b0, bus_if.has_int}, 32'h0);

    // External interrupt through IP2.
    wr(5'd12, 32'h0000_0401);
    cur_ext = 6'b000001;
    idle();
    check("ext_has_int", {31'b0, bus_if.has_int}, 32'h1);
    step(pack(1, 5'h00, 0, 0, 32'h0000_0100, 0, 0, 0, 0), 1'b0);
    check("ext_exl_mask", {31'b0, bus_if.has_int}, 32'h0);
    step(pack(0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0);
    check("ext_after_eret", {31'b0, bus_if.has_int}, 32'h1);
    cur_ext = 6'b0;
    idle();
    check_all("ext_drop");

    // Same-edge priority: ex over mtc0 Status, Compare write over TI set.
    step(pack(1, 5'h00, 0, 0, 32'h0000_0200, 1, 5'd12, 32'h0000_0401, 0), 1'b0);
    check_reg("ex_vs_mtc0_status", 5'd12, 32'h0040_0403);
    step(pack(0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0);
    wr(5'd11, m_count + 32'd6);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (m_count == m_compare && m_tick) begin
        found = 1'b1;
        break;
      end
      idle();
    end
    check("cmp_race_reached", {31'b0, found}, 32'h1);
    wr(5'd11, m_compare);
    rd(5'd13, v);
    check("cmp_race_ti", {31'b0, v[30]}, 32'h0);
    check_all("cmp_race");

    // Count wrap.
    wr(5'd9, 32'hFFFF_FFFF);
    idle();
    idle();
    check_reg("count_wrap", 5'd9, 32'h0);

    // Reset mid-operation beats ex/mtc0.
    wr(5'd9, 32'hFFFF_FFFF);
    cur_ext = 6'h3F;
    step(pack(1, 5'h04, 32'hAAAA_AAAA, 1, 32'h0000_1000, 1, 5'd12, 32'hFFFF_FFFF, 0), 1'b1);
    cur_ext = 6'h0;
    check_reg("rst_badv", 5'd8, 32'h0);
    check_reg("rst_count", 5'd9, 32'h0);
    check_reg("rst_compare", 5'd11, 32'h0);
    check_reg("rst_status", 5'd12, 32'h0040_0000);
    check_reg("rst_cause", 5'd13, 32'h0);
    check_reg("rst_epc", 5'd14, 32'h0);
    check("rst_has_int", {31'b0, bus_if.has_int}, 32'h0);
    check("rst_epc_out", bus_if.epc_out, 32'h0);
    idle(); check_reg("count_seq1", 5'd9, 32'd0);
    idle(); check_reg("count_seq2", 5'd9, 32'd1);
    idle(); check_reg("count_seq3", 5'd9, 32'd1);
    idle(); check_reg("count_seq4", 5'd9, 32'd2);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic r_ex, r_er, r_we, r_bd;
      logic [4:0] r_addr;
      r_ex = ($urandom_range(0, 11) == 0);
      r_er = !r_ex && ($urandom_range(0, 9) == 0);
      r_we = !r_ex && ($urandom_range(0, 2) == 0);
      r_bd = $urandom_range(0, 1) == 1;
      r_addr = raddrs[$urandom_range(0, 8)];
      if ($urandom_range(0, 5) == 0) cur_ext = 6'($urandom);
      step(pack(r_ex, 5'($urandom_range(0, 7)), $urandom, r_bd, $urandom, r_we, r_addr,
                ($urandom_range(0, 3) == 0) ? m_count + 32'($urandom_range(0, 8)) : $urandom,
                r_er), 1'b0);
      check($sformatf("rnd%0d_has_int", i), {31'b0, bus_if.has_int}, {31'b0, m_has_int()});
      check($sformatf("rnd%0d_epc_out", i), bus_if.epc_out, m_epc);
      r_addr = raddrs[$urandom_range(0, 8)];
      check_reg($sformatf("rnd%0d_rd", i), r_addr, mread(r_addr));
      if (i % 25 == 0) check_all($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
